// File: rtl/sha256_digest_checker_pkg.sv
// Shared constants, state encoding and the "abc" known-answer digest for the
// SHA-256 digest checker.
package sha256_pkg;
    localparam int DIGEST_BYTES = 32;
    localparam int IDX_W        = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ARMED = 2'd2,
        RECV  = 2'd3
    } state_t;

    localparam logic [255:0] ABC_DIGEST =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

    // Byte 0 is the most significant byte (h0[31:24]).
    function automatic logic [7:0] digest_byte(input logic [255:0] d, input int idx);
        return d[255 - 8*idx -: 8];
    endfunction
endpackage

// File: rtl/sha256_digest_checker_if.sv
// Expected-digest load port, hasher digest stream and result/status outputs.
interface sha256_digest_checker_if;
    import sha256_pkg::*;

    logic             clear;
    logic [7:0]       exp_data;
    logic             exp_valid;
    logic             exp_ready;
    logic [7:0]       dig_data;
    logic             dig_valid;
    logic             exp_loaded;
    logic             busy;
    logic             done;
    logic             match;
    logic [IDX_W-1:0] mismatch_idx;
    logic             err_timeout;
    logic             err_unarmed;

    modport slave (
        input  clear, exp_data, exp_valid, dig_data, dig_valid,
        output exp_ready, exp_loaded, busy, done, match, mismatch_idx,
               err_timeout, err_unarmed
    );

    modport master (
        output clear, exp_data, exp_valid, dig_data, dig_valid,
        input  exp_ready, exp_loaded, busy, done, match, mismatch_idx,
               err_timeout, err_unarmed
    );
endinterface

// File: rtl/sha256_digest_checker_byte_store.sv
// 32x8 expected-digest register file: one write port, one combinational read port.
module sha256_byte_store
    import sha256_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_clear,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_addr,
    input  logic [7:0]       i_wr_data,
    input  logic [IDX_W-1:0] i_rd_addr,
    output logic [7:0]       o_rd_data
);

    logic [7:0] r_mem [DIGEST_BYTES];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DIGEST_BYTES; i++) r_mem[i] <= '0;
        end else if (i_clear) begin
            for (int i = 0; i < DIGEST_BYTES; i++) r_mem[i] <= '0;
        end else if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/sha256_digest_checker.sv
// Compares a byte-serial SHA-256 digest against a preloaded expected digest;
// reports match, first bad byte index, gap timeouts and unarmed data.
//
// state | meaning
// IDLE  | no expected digest held
// LOAD  | expected digest partially loaded
// ARMED | expected digest held, waiting for a digest stream
// RECV  | digest stream in progress
module sha256_digest_checker
    import sha256_pkg::*;
#(
    parameter int GAP_TIMEOUT = 15
) (
    input logic                    clk,
    input logic                    reset_n,
    sha256_digest_checker_if.slave bus
);

    localparam int GAP_W      = (GAP_TIMEOUT < 2) ? 1 : $clog2(GAP_TIMEOUT);
    localparam int GAP_LOAD_I = (GAP_TIMEOUT > 0) ? GAP_TIMEOUT - 1 : 0;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_LOAD_I[GAP_W-1:0];
    localparam bit   GAP_EN   = (GAP_TIMEOUT > 0);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGEST_BYTES - 1);

    state_t           r_state, w_next;
    logic [IDX_W-1:0] r_exp_idx, r_dig_idx, r_first_bad, r_mismatch_idx;
    logic [GAP_W-1:0] r_gap;
    logic             r_bad, r_done, r_match, r_err_timeout, r_err_unarmed;

    logic             w_exp_ready, w_busy, w_exp_loaded;
    logic             w_exp_acc, w_neq, w_gap_expire;
    logic [7:0]       w_rd_data;

    sha256_byte_store u_store (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_clear   (bus.clear),
        .i_wr_en   (w_exp_acc),
        .i_wr_addr (r_exp_idx),
        .i_wr_data (bus.exp_data),
        .i_rd_addr (r_dig_idx),
        .o_rd_data (w_rd_data)
    );

    assign w_exp_acc    = bus.exp_valid && w_exp_ready;
    assign w_neq        = (w_rd_data != bus.dig_data);
    // Down-counter reloads on every digest byte; an idle cycle at zero aborts.
    assign w_gap_expire = GAP_EN && (r_state == RECV) && !bus.dig_valid && (r_gap == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)       r_state <= IDLE;
        else if (bus.clear) r_state <= IDLE;
        else                r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (w_exp_acc) w_next = LOAD;
            LOAD:  if (w_exp_acc && (r_exp_idx == LAST_IDX)) w_next = ARMED;
            ARMED: begin
                if (bus.dig_valid)  w_next = RECV;
                else if (w_exp_acc) w_next = LOAD;
            end
            RECV: begin
                if (bus.dig_valid && (r_dig_idx == LAST_IDX)) w_next = ARMED;
                else if (w_gap_expire)                        w_next = ARMED;
            end
            default: w_next = IDLE;
        endcase
    end

    // A digest byte in ARMED takes priority, so the expected port stalls that cycle.
    always_comb begin
        w_exp_ready  = 1'b0;
        w_busy       = 1'b0;
        w_exp_loaded = 1'b0;
        case (r_state)
            IDLE, LOAD: w_exp_ready = 1'b1;
            ARMED: begin
                w_exp_ready  = !bus.dig_valid;
                w_busy       = bus.dig_valid;
                w_exp_loaded = 1'b1;
            end
            RECV: begin
                w_busy       = 1'b1;
                w_exp_loaded = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_exp_idx      <= '0;
            r_dig_idx      <= '0;
            r_first_bad    <= '0;
            r_mismatch_idx <= '0;
            r_gap          <= '0;
            r_bad          <= 1'b0;
            r_done         <= 1'b0;
            r_match        <= 1'b0;
            r_err_timeout  <= 1'b0;
            r_err_unarmed  <= 1'b0;
        end else if (bus.clear) begin
            r_exp_idx      <= '0;
            r_dig_idx      <= '0;
            r_first_bad    <= '0;
            r_mismatch_idx <= '0;
            r_gap          <= '0;
            r_bad          <= 1'b0;
            r_done         <= 1'b0;
            r_match        <= 1'b0;
            r_err_timeout  <= 1'b0;
            r_err_unarmed  <= 1'b0;
        end else begin
            r_done        <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_unarmed <= bus.dig_valid && ((r_state == IDLE) || (r_state == LOAD));

            if (w_exp_acc) begin
                if (r_state == LOAD) r_exp_idx <= r_exp_idx + 1'b1;
                else                 r_exp_idx <= IDX_W'(1);
            end

            if (r_state == ARMED && bus.dig_valid) begin
                r_dig_idx   <= IDX_W'(1);
                r_bad       <= w_neq;
                r_first_bad <= '0;
                r_gap       <= GAP_LOAD;
            end else if (r_state == RECV) begin
                if (bus.dig_valid) begin
                    r_dig_idx <= r_dig_idx + 1'b1;
                    r_gap     <= GAP_LOAD;
                    if (w_neq && !r_bad) begin
                        r_bad       <= 1'b1;
                        r_first_bad <= r_dig_idx;
                    end
                    if (r_dig_idx == LAST_IDX) begin
                        r_done         <= 1'b1;
                        r_match        <= !(r_bad || w_neq);
                        r_mismatch_idx <= r_bad ? r_first_bad : (w_neq ? r_dig_idx : '0);
                    end
                end else if (w_gap_expire) begin
                    r_err_timeout <= 1'b1;
                    r_dig_idx     <= '0;
                end else if (GAP_EN) begin
                    r_gap <= r_gap - 1'b1;
                end
            end
        end
    end

    assign bus.exp_ready    = w_exp_ready;
    assign bus.busy         = w_busy;
    assign bus.exp_loaded   = w_exp_loaded;
    assign bus.done         = r_done;
    assign bus.match        = r_match;
    assign bus.mismatch_idx = r_mismatch_idx;
    assign bus.err_timeout  = r_err_timeout;
    assign bus.err_unarmed  = r_err_unarmed;

endmodule
